tone_detector: RTL



---
 rtl/beeper_pkg.sv | 29 ++
 rtl/tone_detector_edge_sync.sv | 28 ++
 rtl/tone_detector.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/beeper_pkg.sv
// Shared types and derived timing constants for the beeper tone path.
// Everything is computed with integer math from the clock rate and tolerance.
package beeper_pkg;

  typedef enum logic [1:0] {CNONE, C512, C1K, COTHER} tone_class_t;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCK_512, LOCK_1K} det_state_t;

  function automatic int period_of(input int clk_hz, input int tone_hz);
    return clk_hz / tone_hz;
  endfunction

  function automatic int lo_of(input int p, input int tol_pct);
    return p - p * tol_pct / 100;
  endfunction

  function automatic int hi_of(input int p, input int tol_pct);
    return p + p * tol_pct / 100;
  endfunction

  // Two slowest-tone periods of silence means the line is dead.
  function automatic int timeout_of(input int clk_hz, input int tol_pct);
    return 2 * hi_of(period_of(clk_hz, 512), tol_pct);
  endfunction

  function automatic int cnt_w_of(input int clk_hz, input int tol_pct);
    return $clog2(timeout_of(clk_hz, tol_pct) + 1);
  endfunction

endpackage

// File: rtl/tone_detector_edge_sync.sv
// Two-flop synchronizer for the asynchronous beep line plus a rising-edge strobe.
// The strobe is high for one cycle, two to three cycles after the line rises.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic beep_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= beep_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/tone_detector.sv
// Measures the period between rising edges of the beep line and locks onto
// a stable 512 Hz or 1 kHz tone after MATCH_N consecutive matching periods.
module tone_detector
  import beeper_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TOL_PCT = 10,
  parameter int MATCH_N = 4,
  localparam int CNT_W  = cnt_w_of(CLK_HZ, TOL_PCT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             beep_in,
  output logic             tone_512,
  output logic             tone_1k,
  output logic             lock_pulse,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] period
);

  localparam int P1K  = period_of(CLK_HZ, 1000);
  localparam int P512 = period_of(CLK_HZ, 512);
  localparam logic [CNT_W-1:0] LO1K    = CNT_W'(lo_of(P1K, TOL_PCT));
  localparam logic [CNT_W-1:0] HI1K    = CNT_W'(hi_of(P1K, TOL_PCT));
  localparam logic [CNT_W-1:0] LO512   = CNT_W'(lo_of(P512, TOL_PCT));
  localparam logic [CNT_W-1:0] HI512   = CNT_W'(hi_of(P512, TOL_PCT));
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(timeout_of(CLK_HZ, TOL_PCT));
  localparam int MW = $clog2(MATCH_N + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(MATCH_N);

  logic             strobe;
  det_state_t       state_q;
  tone_class_t      cand_q;
  tone_class_t      meas_cls;
  tone_class_t      lock_cls;
  logic [MW-1:0]    match_q;
  logic [MW-1:0]    match_upd;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic             tone_512_q;
  logic             tone_1k_q;
  logic             lock_pulse_q;
  logic             drop_pulse_q;
  logic             timeout;
  logic             locked;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .beep_i (beep_in),
    .rise_o (strobe)
  );

  assign timeout  = (cnt_q == TIMEOUT);
  assign locked   = (state_q == LOCK_512) || (state_q == LOCK_1K);
  assign lock_cls = (state_q == LOCK_512) ? C512 : C1K;

  // On a strobe cycle cnt_q holds the clocks since the previous strobe.
  always_comb begin
    meas_cls = COTHER;
    if (cnt_q >= LO1K && cnt_q <= HI1K) begin
      meas_cls = C1K;
    end else if (cnt_q >= LO512 && cnt_q <= HI512) begin
      meas_cls = C512;
    end
  end

  always_comb begin
    match_upd = MW'(1);
    if (meas_cls == cand_q) begin
      match_upd = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cand_q       <= CNONE;
      match_q      <= '0;
      cnt_q        <= '0;
      period_q     <= '0;
      tone_512_q   <= 1'b0;
      tone_1k_q    <= 1'b0;
      lock_pulse_q <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      lock_pulse_q <= 1'b0;
      drop_pulse_q <= 1'b0;
      if (!en) begin
        state_q      <= IDLE;
        cand_q       <= CNONE;
        match_q      <= '0;
        cnt_q        <= '0;
        period_q     <= '0;
        tone_512_q   <= 1'b0;
        tone_1k_q    <= 1'b0;
        drop_pulse_q <= locked;
      end else begin
        cnt_q <= strobe ? CNT_W'(1) : (timeout ? TIMEOUT : cnt_q + CNT_W'(1));
        // An edge after a dead line only restarts timing; it is not a measurement.
        if (strobe && (state_q == IDLE || timeout)) begin
          state_q      <= ACQUIRE;
          match_q      <= '0;
          tone_512_q   <= 1'b0;
          tone_1k_q    <= 1'b0;
          drop_pulse_q <= locked;
        end else if (timeout) begin
          state_q      <= IDLE;
          tone_512_q   <= 1'b0;
          tone_1k_q    <= 1'b0;
          drop_pulse_q <= locked;
        end else if (strobe && state_q == ACQUIRE) begin
          period_q <= cnt_q;
          cand_q   <= meas_cls;
          match_q  <= match_upd;
          if (match_upd == MATCH_MAX && meas_cls == C512) begin
            state_q      <= LOCK_512;
            tone_512_q   <= 1'b1;
            lock_pulse_q <= 1'b1;
          end else if (match_upd == MATCH_MAX && meas_cls == C1K) begin
            state_q      <= LOCK_1K;
            tone_1k_q    <= 1'b1;
            lock_pulse_q <= 1'b1;
          end
        end else if (strobe) begin
          period_q <= cnt_q;
          if (meas_cls != lock_cls) begin
            state_q      <= ACQUIRE;
            cand_q       <= meas_cls;
            match_q      <= MW'(1);
            tone_512_q   <= 1'b0;
            tone_1k_q    <= 1'b0;
            drop_pulse_q <= 1'b1;
          end
        end
      end
    end
  end

  assign tone_512   = tone_512_q;
  assign tone_1k    = tone_1k_q;
  assign lock_pulse = lock_pulse_q;
  assign drop_pulse = drop_pulse_q;
  assign period     = period_q;

endmodule
